bus_burst_slave: RTL

- Burst-capable, single-ported on-chip SRAM slave for the shared processor bus.
- Directly consumes the DMA controller's bus transactions: the DMA's address/data, begin, end, burst size, byte-enable and read/write outputs land here. This slave's data/valid/end/busy/error outputs feed the DMA's bus inputs.
- Decodes an address window, stores or returns word bursts, and signals end-of-transaction and bus errors.
- All outputs are driven to 0 when the slave is not the active target, so they can be OR-combined on the bus.

---
 rtl/bus_burst_slave.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bus_burst_slave.sv
// bus_burst_slave: burst SRAM slave on the shared bus with window decode and bus-error reporting.
// Optional wait states (write busy, read stalls) are compiled in with BUS_SLAVE_WAITSTATE_EN.
module bus_burst_slave #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int addrWidth = 10,
    parameter int readLatency = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busyOut,
    output logic        busErrorOut
);
    localparam int AW = addrWidth;
    localparam logic [AW-1:0] LAST = '1;
    localparam logic [2:0] IDLE = 3'd0, READ_WAIT = 3'd1, READ = 3'd2, WRITE = 3'd3, WERR = 3'd4, END = 3'd5;

    logic          r_begin, r_end, r_rnw, r_dv;
    logic [3:0]    r_be_in;
    logic [7:0]    r_bs;
    logic [31:0]   r_ad;
    logic [2:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [8:0]    r_cnt;
    logic [3:0]    r_be;
    logic [7:0]    r_wait;
    logic          r_past, r_rerr;
    logic [31:0]   r_mem [2**AW];
    logic          w_hit, w_accept, w_we, w_stall, w_busy_next;
    logic [31:0]   w_mask, w_rdata;

`ifdef BUS_SLAVE_WAITSTATE_EN
    logic [1:0] r_ws;
    always_ff @(posedge clock or negedge reset)
        if (!reset) r_ws <= 2'd0;
        else r_ws <= r_ws + 2'd1;
    // busy is registered from ws==2 so it is visible while the counter reads 3
    assign w_stall     = r_ws == 2'd3;
    assign w_busy_next = r_ws == 2'd2;
`else
    assign w_stall     = 1'b0;
    assign w_busy_next = 1'b0;
`endif

    assign w_hit    = r_ad[31:AW+2] == baseAddress[31:AW+2];
    assign w_mask   = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
    assign w_rdata  = r_mem[r_idx] & w_mask;
    assign w_accept = r_state == WRITE && r_dv && !busyOut;
    assign w_we     = w_accept && r_cnt != 9'd0 && !r_past;

    always_ff @(posedge clock)
        if (w_we)
            for (int i = 0; i < 4; i++)
                if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_ad[8*i +: 8];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {r_begin, r_end, r_rnw, r_dv, r_be_in, r_bs, r_ad} <= '0;
            {r_state, r_idx, r_cnt, r_be, r_wait, r_past, r_rerr} <= '0;
            {addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut} <= '0;
        end else begin
            r_begin <= beginTransactionIn;
            r_end <= endTransactionIn;
            r_rnw <= readNotWriteIn;
            r_dv <= dataValidIn;
            r_be_in <= byteEnablesIn;
            r_bs <= burstSizeIn;
            r_ad <= addressDataIn;
            {addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut} <= '0;
            case (r_state)
                IDLE: if (r_begin && w_hit) begin
                    r_idx <= r_ad[AW+1:2];
                    r_cnt <= {1'b0, r_bs} + 9'd1;
                    r_be <= r_be_in;
                    r_past <= 1'b0;
                    r_rerr <= 1'b0;
                    r_wait <= 8'(readLatency - 1);
                    r_state <= r_rnw ? (readLatency > 1 ? READ_WAIT : READ) : WRITE;
                    busyOut <= !r_rnw && w_busy_next;
                end
                READ_WAIT: begin
                    r_wait <= r_wait - 8'd1;
                    if (r_wait == 8'd1) r_state <= READ;
                end
                READ: if (!w_stall) begin
                    addressDataOut <= w_rdata;
                    dataValidOut <= 1'b1;
                    r_cnt <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) r_state <= END;
                    else if (r_idx == LAST) begin
                        r_rerr <= 1'b1;
                        r_state <= END;
                    end else r_idx <= r_idx + 1'b1;
                end
                WRITE: begin
                    if (w_we) begin
                        r_cnt <= r_cnt - 9'd1;
                        if (r_idx == LAST) r_past <= 1'b1;
                        else r_idx <= r_idx + 1'b1;
                    end
                    busErrorOut <= w_accept && !w_we;
                    r_state <= r_end ? IDLE : (w_accept && !w_we) ? WERR : WRITE;
                    busyOut <= !r_end && !(w_accept && !w_we) && w_busy_next;
                end
                WERR: if (r_end) r_state <= IDLE;
                END: begin
                    endTransactionOut <= 1'b1;
                    busErrorOut <= r_rerr;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
